// File: rtl/mem_rw_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_rw_initiator
// Brief    : Requester-side master for the byte-oriented memory R/W controller
// Revision : 1.0 - initial release
// ============================================================================
module mem_rw_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_rw,
  input  logic [5:0] i_cmd_addr,
  input  logic [3:0] i_cmd_num_b,
  input  logic [7:0] i_wdat,
  input  logic       i_wdat_valid,
  output logic       o_wdat_ready,
  output logic [7:0] o_rdat,
  output logic       o_rdat_valid,
  output logic       o_cmd_done,
  output logic [2:0] o_cmd_status,
  output logic [2:0] o_err_code_q,
  output logic       o_wr_req,
  input  logic       i_wr_ack,
  output logic [7:0] o_wr_data,
  output logic       o_wr_valid,
  input  logic       i_wr_done,
  output logic       o_rd_req,
  input  logic       i_rd_ack,
  input  logic [7:0] i_rd_data,
  input  logic       i_rd_valid,
  output logic       o_rd_done,
  output logic [5:0] o_addr,
  output logic [3:0] o_num_b,
  input  logic       i_err,
  input  logic [2:0] i_err_code,
  output logic       o_err_ack
);

  localparam logic [7:0] c_TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0] c_ST_OK      = 3'd0;
  localparam logic [2:0] c_ST_TIMEOUT = 3'd1;
  localparam logic [2:0] c_ST_CTRLERR = 3'd2;
  localparam logic [2:0] c_ST_BADLEN  = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_REQ  = 4'd1,
    S_WR_DATA = 4'd2,
    S_WR_WAIT = 4'd3,
    S_RD_REQ  = 4'd4,
    S_RD_DATA = 4'd5,
    S_RD_FIN  = 4'd6,
    S_ERR     = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t     r_state;
  logic [3:0] r_remaining;
  logic [7:0] r_timer;
  logic [2:0] r_pend_status;
  logic       r_idle_err_seen;

  logic       w_wait_state;
  logic       w_progress;
  logic       w_wdat_take;
  logic       w_rd_take;
  logic       w_tmo;
  logic       w_err_abort;
  logic [7:0] w_timer_inc;

  assign o_wdat_ready = (r_state == S_WR_DATA) && (r_remaining != 4'd0);
  assign w_wdat_take  = i_wdat_valid && o_wdat_ready;
  assign w_rd_take    = (r_state == S_RD_DATA) && i_rd_valid && (r_remaining != 4'd0);
  assign w_tmo        = (r_timer == c_TMO_LAST);
  assign w_timer_inc  = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;
  assign w_err_abort  = i_err && (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);

  always_comb begin
    w_wait_state = 1'b0;
    w_progress   = 1'b0;
    case (r_state)
      S_WR_REQ:  begin w_wait_state = 1'b1; w_progress = i_wr_ack;    end
      S_WR_DATA: begin w_wait_state = 1'b1; w_progress = w_wdat_take; end
      S_WR_WAIT: begin w_wait_state = 1'b1; w_progress = i_wr_done;   end
      S_RD_REQ:  begin w_wait_state = 1'b1; w_progress = i_rd_ack;    end
      S_RD_DATA: begin w_wait_state = 1'b1; w_progress = w_rd_take;   end
      default:   begin w_wait_state = 1'b0; w_progress = 1'b0;        end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state         <= S_IDLE;
      r_remaining     <= 4'd0;
      r_timer         <= 8'd0;
      r_pend_status   <= c_ST_OK;
      r_idle_err_seen <= 1'b0;
      o_cmd_ready     <= 1'b1;
      o_rdat          <= 8'd0;
      o_rdat_valid    <= 1'b0;
      o_cmd_done      <= 1'b0;
      o_cmd_status    <= 3'd0;
      o_err_code_q    <= 3'd0;
      o_wr_req        <= 1'b0;
      o_wr_data       <= 8'd0;
      o_wr_valid      <= 1'b0;
      o_rd_req        <= 1'b0;
      o_rd_done       <= 1'b0;
      o_addr          <= 6'd0;
      o_num_b         <= 4'd0;
      o_err_ack       <= 1'b0;
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      o_cmd_done   <= 1'b0;
      o_err_ack    <= 1'b0;
      o_wr_valid   <= 1'b0;
      o_rdat_valid <= 1'b0;
      o_rd_done    <= 1'b0;
      if (!i_err) r_idle_err_seen <= 1'b0;

      if (w_err_abort) begin
        r_state      <= S_ERR;
        o_err_code_q <= i_err_code;
        o_err_ack    <= 1'b1;
        o_wr_req     <= 1'b0;
        o_rd_req     <= 1'b0;
      end else if (w_wait_state && !w_progress && w_tmo) begin
        r_state       <= S_DONE;
        r_pend_status <= c_ST_TIMEOUT;
        o_wr_req      <= 1'b0;
        o_rd_req      <= 1'b0;
      end else begin
        if (w_wait_state) r_timer <= w_progress ? 8'd0 : w_timer_inc;
        case (r_state)
          S_IDLE: begin
            if (i_err && !r_idle_err_seen) begin
              r_idle_err_seen <= 1'b1;
              o_err_code_q    <= i_err_code;
              o_err_ack       <= 1'b1;
            end
            if (i_cmd_valid) begin
              o_cmd_ready <= 1'b0;
              o_addr      <= i_cmd_addr;
              o_num_b     <= i_cmd_num_b;
              r_remaining <= i_cmd_num_b;
              r_timer     <= 8'd0;
              if (i_cmd_num_b == 4'd0) begin
                r_state       <= S_DONE;
                r_pend_status <= c_ST_BADLEN;
              end else if (i_cmd_rw) begin
                r_state  <= S_WR_REQ;
                o_wr_req <= 1'b1;
              end else begin
                r_state  <= S_RD_REQ;
                o_rd_req <= 1'b1;
              end
            end
          end
          S_WR_REQ: if (i_wr_ack) begin
            o_wr_req <= 1'b0;
            r_state  <= S_WR_DATA;
          end
          S_WR_DATA: if (w_wdat_take) begin
            o_wr_data   <= i_wdat;
            o_wr_valid  <= 1'b1;
            r_remaining <= r_remaining - 4'd1;
            if (r_remaining == 4'd1) r_state <= S_WR_WAIT;
          end
          S_WR_WAIT: if (i_wr_done) begin
            r_state       <= S_DONE;
            r_pend_status <= c_ST_OK;
          end
          S_RD_REQ: if (i_rd_ack) begin
            o_rd_req <= 1'b0;
            r_state  <= S_RD_DATA;
          end
          S_RD_DATA: if (w_rd_take) begin
            o_rdat       <= i_rd_data;
            o_rdat_valid <= 1'b1;
            r_remaining  <= r_remaining - 4'd1;
            if (r_remaining == 4'd1) begin
              r_state   <= S_RD_FIN;
              o_rd_done <= 1'b1;
            end
          end
          S_RD_FIN: begin
            r_state       <= S_DONE;
            r_pend_status <= c_ST_OK;
          end
          S_ERR: if (!i_err) begin
            r_state       <= S_DONE;
            r_pend_status <= c_ST_CTRLERR;
          end
          S_DONE: begin
            o_cmd_done   <= 1'b1;
            o_cmd_status <= r_pend_status;
            o_cmd_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_rw_initiator.md
Name: mem_rw_initiator

Overview:
- Requester-side master for the byte-oriented memory read/write controller.
- Accepts single commands (read or write, 6-bit address, 1..15 bytes) from a local host port and drives the controller's write or read channel handshake.
- Streams write bytes from the host, or returns read bytes to the host.
- Services the controller's error report, enforces a no-progress timeout, and reports per-command completion status.

Parameters:
TIMEOUT, 16, cycles without progress in any wait state before the command aborts with status TIMEOUT (legal range 2..255)

Ports:
i_clk  in  1  clock; all logic rising-edge
i_reset  in  1  synchronous reset, active-low
i_cmd_valid  in  1  host command present
o_cmd_ready  out  1  high only in IDLE
i_cmd_rw  in  1  1 = write, 0 = read
i_cmd_addr  in  6  start address
i_cmd_num_b  in  4  byte count
i_wdat  in  8  host write byte
i_wdat_valid  in  1  host write byte present
o_wdat_ready  out  1  initiator takes i_wdat this cycle
o_rdat  out  8  read byte to host
o_rdat_valid  out  1  o_rdat valid, 1-cycle pulse per byte
o_cmd_done  out  1  1-cycle completion pulse
o_cmd_status  out  3  0 OK, 1 TIMEOUT, 2 CTRL_ERR, 3 BAD_LEN; held until next o_cmd_done
o_err_code_q  out  3  latched controller error code
o_wr_req  out  1  write request to controller
i_wr_ack  in  1  controller grants write
o_wr_data  out  8  write byte
o_wr_valid  out  1  write byte valid
i_wr_done  in  1  controller finished write
o_rd_req  out  1  read request
i_rd_ack  in  1  controller grants read
i_rd_data  in  8  read byte
i_rd_valid  in  1  read byte valid
o_rd_done  out  1  1-cycle pulse after the last read byte
o_addr  out  6  shared address, held for the whole command
o_num_b  out  4  shared byte count, held for the whole command
i_err  in  1  controller error flag
i_err_code  in  3  controller error code
o_err_ack  out  1  error acknowledge

Behaviour:
- Reset (i_reset low at a clock edge, from any state, including mid-transfer):
  - state IDLE.
  - All outputs 0, except o_cmd_ready = 1.
  - Counters cleared; no o_cmd_done is issued for the abandoned command.
- States: IDLE, WR_REQ, WR_DATA, WR_WAIT, RD_REQ, RD_DATA, RD_FIN, ERR, DONE.
- IDLE:
  - Command accepted when i_cmd_valid & o_cmd_ready; latch addr, num_b, rw; remaining = num_b; timer = 0.
  - num_b == 0 -> DONE with BAD_LEN; no controller request.
  - Otherwise -> WR_REQ or RD_REQ.
- WR_REQ: o_wr_req = 1 until i_wr_ack is sampled high -> WR_DATA; o_wr_req deasserts the same edge.
- WR_DATA:
  - o_wdat_ready = (remaining != 0).
  - On i_wdat_valid & o_wdat_ready: o_wr_data <= i_wdat, o_wr_valid <= 1 next cycle, remaining decrements; otherwise o_wr_valid <= 0.
  - The controller applies no backpressure.
  - After the last byte is registered -> WR_WAIT; that byte's o_wr_valid pulse still occurs.
- WR_WAIT: i_wr_done high -> DONE with OK. i_wr_done asserted before the last byte is ignored.
- RD_REQ: o_rd_req = 1 until i_rd_ack -> RD_DATA.
- RD_DATA:
  - Each i_rd_valid: o_rdat <= i_rd_data, o_rdat_valid pulses next cycle (latency 1), remaining decrements.
  - remaining hits 0 -> RD_FIN.
  - Extra i_rd_valid after the count is ignored.
- RD_FIN: o_rd_done = 1 for exactly one cycle -> DONE with OK.
- DONE: o_cmd_done = 1 for one cycle, o_cmd_status updated -> IDLE. The earliest next command is accepted the following cycle.
- Timeout:
  - timer runs in WR_REQ, WR_DATA (only while waiting on host data after ack), WR_WAIT, RD_REQ, RD_DATA.
  - timer clears on state change, on each byte transferred, and on each host byte accepted.
  - timer == TIMEOUT-1 with no progress -> DONE with TIMEOUT.
  - On abort, o_wr_req, o_rd_req and o_wr_valid drop the next cycle.
- Error handling:
  - i_err high in any non-IDLE, non-DONE state overrides all other transitions -> ERR.
  - Entering ERR latches i_err_code into o_err_code_q.
  - ERR: o_err_ack = 1 for exactly one cycle, then wait for i_err low -> DONE with CTRL_ERR.
  - All request/valid outputs are 0 in ERR.
- i_err in IDLE: ack once (one-cycle o_err_ack), latch the code, no o_cmd_done; o_cmd_ready stays 1.
- Simultaneous events:
  - i_err with i_wr_done or the last i_rd_valid: error wins.
  - i_cmd_valid during reset: ignored.
- Width rules:
  - remaining 4-bit, never wraps (decrement only when nonzero).
  - timer 8-bit, saturating.

Test Plan:
- Write addr 0x05 num_b 3, host bytes 0xA1, 0xB2, 0xC3, ack after 2 cycles, wr_done 4 cycles after the last byte -> o_wr_req high 2 cycles; exactly three o_wr_valid pulses with those bytes; o_addr = 0x05 and o_num_b = 3 throughout; o_cmd_done with status 0.
- Read addr 0x3F num_b 2, controller returns 0x11 then 0x22 with a gap -> o_rdat_valid pulses 0x11, 0x22 one cycle after each i_rd_valid; o_rd_done pulses once; then status 0.
- num_b = 0 -> no o_wr_req or o_rd_req; o_cmd_done with status 3 two cycles after acceptance.
- Write, controller never acks, TIMEOUT = 16 -> o_wr_req high 16 cycles, then o_cmd_done with status 1.
- Read in progress, i_err = 1 with code 5 after 1 byte -> o_err_ack one-cycle pulse; o_err_code_q = 5; after i_err falls, status 2; o_rd_done never asserted.
- Reset pulled low mid-WR_DATA for 1 cycle -> next cycle all outputs 0 except o_cmd_ready = 1; no o_cmd_done; a new read command then completes normally.
